// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared definitions for the two-core snoop bus arbiter: bus widths and
// the transaction FSM state encoding.
package snoop_bus_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RESP
    } state_t;

endpackage

// File: rtl/snoop_bus_arbiter_if.sv
// Bundle of both core request/response ports and the memory port.
// slave is the arbiter's view; master is the cores-plus-memory side.
interface snoop_bus_arbiter_if #(
    parameter int ADDR_W = snoop_bus_arbiter_pkg::ADDR_W,
    parameter int LINE_W = snoop_bus_arbiter_pkg::LINE_W
);

    logic              c0_rd_req;
    logic [ADDR_W-1:0] c0_rd_addr;
    logic              c0_ev_wren;
    logic [ADDR_W-1:0] c0_ev_addr;
    logic [LINE_W-1:0] c0_ev_line;
    logic [LINE_W-1:0] c0_line;
    logic              c0_line_valid;
    logic              c0_ack;

    logic              c1_rd_req;
    logic [ADDR_W-1:0] c1_rd_addr;
    logic              c1_ev_wren;
    logic [ADDR_W-1:0] c1_ev_addr;
    logic [LINE_W-1:0] c1_ev_line;
    logic [LINE_W-1:0] c1_line;
    logic              c1_line_valid;
    logic              c1_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_wren;
    logic              mem_rden;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  c0_rd_req, c0_rd_addr, c0_ev_wren, c0_ev_addr, c0_ev_line,
        output c0_line, c0_line_valid, c0_ack,
        input  c1_rd_req, c1_rd_addr, c1_ev_wren, c1_ev_addr, c1_ev_line,
        output c1_line, c1_line_valid, c1_ack,
        output mem_addr, mem_wdata, mem_wren, mem_rden,
        input  mem_rdata, mem_ack
    );

    modport master (
        output c0_rd_req, c0_rd_addr, c0_ev_wren, c0_ev_addr, c0_ev_line,
        input  c0_line, c0_line_valid, c0_ack,
        output c1_rd_req, c1_rd_addr, c1_ev_wren, c1_ev_addr, c1_ev_line,
        input  c1_line, c1_line_valid, c1_ack,
        input  mem_addr, mem_wdata, mem_wren, mem_rden,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/snoop_bus_arbiter_rr.sv
// Two-way round-robin grant selection: a lone requester wins, a tie goes
// to the core that was not granted last.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        unique case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = ~last_grant;
        endcase
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Two-core snoop bus arbiter: grants one core at a time, runs an optional
// eviction write then an optional line read, and acknowledges that core.
module snoop_bus_arbiter #(
    parameter int ADDR_W = snoop_bus_arbiter_pkg::ADDR_W,
    parameter int LINE_W = snoop_bus_arbiter_pkg::LINE_W
) (
    input logic                clk,
    input logic                reset,
    snoop_bus_arbiter_if.slave bus
);
    import snoop_bus_arbiter_pkg::*;

    state_t            state;
    state_t            state_nxt;

    logic [1:0]        req;
    logic              pick;
    logic              last_grant;

    logic              sel_rd;
    logic              sel_ev;
    logic [ADDR_W-1:0] sel_rd_addr;
    logic [ADDR_W-1:0] sel_ev_addr;
    logic [LINE_W-1:0] sel_ev_line;

    logic              gnt;
    logic              lat_rd;
    logic              lat_ev;
    logic [ADDR_W-1:0] lat_rd_addr;
    logic [ADDR_W-1:0] lat_ev_addr;
    logic [LINE_W-1:0] lat_ev_line;

    logic [LINE_W-1:0] line0_q;
    logic [LINE_W-1:0] line1_q;

    assign req = {bus.c1_rd_req | bus.c1_ev_wren, bus.c0_rd_req | bus.c0_ev_wren};

    rr_arbiter_2 u_rr (
        .req        (req),
        .last_grant (last_grant),
        .grant      (pick)
    );

    always_comb begin
        if (pick) begin
            sel_rd      = bus.c1_rd_req;
            sel_ev      = bus.c1_ev_wren;
            sel_rd_addr = bus.c1_rd_addr;
            sel_ev_addr = bus.c1_ev_addr;
            sel_ev_line = bus.c1_ev_line;
        end else begin
            sel_rd      = bus.c0_rd_req;
            sel_ev      = bus.c0_ev_wren;
            sel_rd_addr = bus.c0_rd_addr;
            sel_ev_addr = bus.c0_ev_addr;
            sel_ev_line = bus.c0_ev_line;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // mem_ack only matters while a strobe is up; IDLE and RESP ignore it
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt = sel_ev ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (bus.mem_ack) begin
                    state_nxt = lat_rd ? ST_READ : ST_RESP;
                end
            end
            ST_READ: begin
                if (bus.mem_ack) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Request inputs are only looked at in IDLE; the latched copy drives the rest
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt         <= 1'b0;
            last_grant  <= 1'b1;
            lat_rd      <= 1'b0;
            lat_ev      <= 1'b0;
            lat_rd_addr <= '0;
            lat_ev_addr <= '0;
            lat_ev_line <= '0;
            line0_q     <= '0;
            line1_q     <= '0;
        end else begin
            if (state == ST_IDLE && (|req)) begin
                gnt         <= pick;
                lat_rd      <= sel_rd;
                lat_ev      <= sel_ev;
                lat_rd_addr <= sel_rd_addr;
                lat_ev_addr <= sel_ev_addr;
                lat_ev_line <= sel_ev_line;
            end
            if (state == ST_READ && bus.mem_ack) begin
                if (gnt) begin
                    line1_q <= bus.mem_rdata;
                end else begin
                    line0_q <= bus.mem_rdata;
                end
            end
            if (state == ST_RESP) begin
                last_grant <= gnt;
            end
        end
    end

    always_comb begin
        bus.mem_wren      = 1'b0;
        bus.mem_rden      = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        bus.c0_ack        = 1'b0;
        bus.c1_ack        = 1'b0;
        bus.c0_line_valid = 1'b0;
        bus.c1_line_valid = 1'b0;
        unique case (state)
            ST_WRITE: begin
                bus.mem_wren  = 1'b1;
                bus.mem_addr  = lat_ev_addr;
                bus.mem_wdata = lat_ev_line;
            end
            ST_READ: begin
                bus.mem_rden = 1'b1;
                bus.mem_addr = lat_rd_addr;
            end
            ST_RESP: begin
                if (gnt) begin
                    bus.c1_ack        = 1'b1;
                    bus.c1_line_valid = lat_rd;
                end else begin
                    bus.c0_ack        = 1'b1;
                    bus.c0_line_valid = lat_rd;
                end
            end
            default: ;
        endcase
    end

    assign bus.c0_line = line0_q;
    assign bus.c1_line = line1_q;

    mem_strobe_excl: assert property (@(posedge clk) disable iff (reset)
        !(bus.mem_wren && bus.mem_rden));

    resp_single_cycle: assert property (@(posedge clk) disable iff (reset)
        (state == ST_RESP) |=> (state == ST_IDLE));

    evict_only_skips_read: assert property (@(posedge clk) disable iff (reset)
        (state == ST_READ) |-> lat_rd);

    unused_ok: assert property (@(posedge clk) disable iff (reset)
        (state == ST_WRITE) |-> lat_ev);

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Scoreboard bench: core drivers push expected responses, an ack monitor pops
// and compares them, and a memory responder records every strobe it serves.
module tb_snoop_bus_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;

    typedef struct packed {
        bit          rd;
        bit          ev;
        logic [AW-1:0] rd_addr;
        logic [AW-1:0] ev_addr;
        logic [LW-1:0] ev_line;
        bit          drop_in_read;
        int          exp_lat;
    } cmd_t;

    typedef struct packed {
        bit          rd;
        logic [LW-1:0] line;
        int          issue_cyc;
        int          exp_lat;
    } exp_t;

    typedef struct packed {
        bit          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } acc_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    snoop_bus_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    snoop_bus_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    cmd_t cmd_q [2][$];
    exp_t exp_q [2][$];
    cmd_t cur [2];
    bit   active [2];
    int   ack_log [$];
    acc_t mem_log [$];
    logic [LW-1:0] mem_model [logic [AW-1:0]];
    logic [LW-1:0] line_model [2];
    int   mem_delay = 0;
    int   wait_cnt = 0;
    bit   stray_ack = 1'b0;
    bit   abort_req = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [LW-1:0] mem_peek(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a ^ 32'hDEAD_BEEF, ~a, a, a + 32'h1111_1111};
    endfunction

    function automatic logic get_ack(input int n);
        return (n == 0) ? bus.c0_ack : bus.c1_ack;
    endfunction

    function automatic logic get_lv(input int n);
        return (n == 0) ? bus.c0_line_valid : bus.c1_line_valid;
    endfunction

    function automatic logic [LW-1:0] get_line(input int n);
        return (n == 0) ? bus.c0_line : bus.c1_line;
    endfunction

    task automatic drive_core(input int n, input bit rd, input bit ev, input cmd_t c);
        if (n == 0) begin
            bus.c0_rd_req  = rd;
            bus.c0_ev_wren = ev;
            bus.c0_rd_addr = c.rd_addr;
            bus.c0_ev_addr = c.ev_addr;
            bus.c0_ev_line = c.ev_line;
        end else begin
            bus.c1_rd_req  = rd;
            bus.c1_ev_wren = ev;
            bus.c1_rd_addr = c.rd_addr;
            bus.c1_ev_addr = c.ev_addr;
            bus.c1_ev_line = c.ev_line;
        end
    endtask

    // Core drivers: hold each request level until its ack, then load the next one
    always @(negedge clk) begin
        exp_t e;
        for (int n = 0; n < 2; n++) begin
            if (abort_req) begin
                active[n] = 1'b0;
                cmd_q[n].delete();
                exp_q[n].delete();
            end else if (active[n] && get_ack(n)) begin
                active[n] = 1'b0;
                ack_log.push_back(n);
            end else if (active[n] && cur[n].drop_in_read && bus.mem_rden) begin
                drive_core(n, 1'b0, 1'b0, cur[n]);
            end
            if (!active[n]) begin
                drive_core(n, 1'b0, 1'b0, '0);
                if (!abort_req && cmd_q[n].size() > 0) begin
                    cur[n] = cmd_q[n].pop_front();
                    drive_core(n, cur[n].rd, cur[n].ev, cur[n]);
                    active[n] = 1'b1;
                    e.rd = cur[n].rd;
                    if (!cur[n].rd) e.line = '0;
                    else if (cur[n].ev && cur[n].ev_addr == cur[n].rd_addr) e.line = cur[n].ev_line;
                    else e.line = mem_peek(cur[n].rd_addr);
                    e.issue_cyc = cyc;
                    e.exp_lat = cur[n].exp_lat;
                    exp_q[n].push_back(e);
                end
            end
        end
        abort_req = 1'b0;
    end

    // Memory: ack after mem_delay extra strobe cycles, commit writes, serve reads
    always @(negedge clk) begin
        logic [AW-1:0] a;
        bus.mem_ack = 1'b0;
        if (stray_ack) begin
            bus.mem_ack = 1'b1;
            stray_ack = 1'b0;
        end
        if (!reset && (bus.mem_wren || bus.mem_rden)) begin
            tests++;
            if (bus.mem_wren && bus.mem_rden) begin
                fails++;
                $display("FAIL strobe_excl: wren=%b rden=%b, required not both high", bus.mem_wren, bus.mem_rden);
            end
            if (wait_cnt >= mem_delay) begin
                bus.mem_ack = 1'b1;
                wait_cnt = 0;
                a = bus.mem_addr;
                if (bus.mem_wren) begin
                    mem_model[a] = bus.mem_wdata;
                    mem_log.push_back('{wr: 1'b1, addr: a, data: bus.mem_wdata});
                end else begin
                    bus.mem_rdata = mem_peek(a);
                    mem_log.push_back('{wr: 1'b0, addr: a, data: bus.mem_rdata});
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Ack monitor; latency is counted in posedges from the issuing negedge,
    // i.e. one less than the inclusive IDLE..RESP cycle count
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            line_model[0] = '0;
            line_model[1] = '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (get_ack(n)) begin
                    tests++;
                    if (exp_q[n].size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_ack core%0d: got ack=1, required no ack", n);
                    end else begin
                        e = exp_q[n].pop_front();
                        if (e.rd) line_model[n] = e.line;
                        tests++;
                        if (get_lv(n) !== e.rd) begin
                            fails++;
                            $display("FAIL line_valid core%0d: got %b required %b", n, get_lv(n), e.rd);
                        end
                        tests++;
                        if (get_line(n) !== line_model[n]) begin
                            fails++;
                            $display("FAIL line core%0d: got %h required %h", n, get_line(n), line_model[n]);
                        end
                        if (e.exp_lat >= 0) begin
                            tests++;
                            if (cyc - e.issue_cyc != e.exp_lat) begin
                                fails++;
                                $display("FAIL latency core%0d: got %0d required %0d", n, cyc - e.issue_cyc, e.exp_lat);
                            end
                        end
                    end
                end else if (get_lv(n) !== 1'b0) begin
                    tests++;
                    fails++;
                    $display("FAIL lone_line_valid core%0d: got %b required 0", n, get_lv(n));
                end
            end
        end
    end

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!active[0] && !active[1] && cmd_q[0].size() == 0 && cmd_q[1].size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.c0_ack, bus.c1_ack, bus.c0_line_valid, bus.c1_line_valid, bus.mem_wren, bus.mem_rden} !== 6'b0) begin
            fails++;
            $display("FAIL reset_strobes: got %b required 000000",
                {bus.c0_ack, bus.c1_ack, bus.c0_line_valid, bus.c1_line_valid, bus.mem_wren, bus.mem_rden});
        end
        tests++;
        if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            fails++;
            $display("FAIL reset_mem_bus: got addr=%h wdata=%h required 0", bus.mem_addr, bus.mem_wdata);
        end
        tests++;
        if (bus.c0_line !== '0 || bus.c1_line !== '0) begin
            fails++;
            $display("FAIL reset_lines: got c0=%h c1=%h required 0", bus.c0_line, bus.c1_line);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({bus.mem_wren, bus.mem_rden} !== 2'b00) begin
            fails++;
            $display("FAIL idle_no_request: got %b required 00", {bus.mem_wren, bus.mem_rden});
        end
    endtask

    task automatic test_read_only();
        cmd_t c;
        bit ok;
        mem_model[32'h0000_1230] = {32{4'hA}};
        mem_delay = 0;
        mem_log.delete();
        c = '0;
        c.rd = 1'b1;
        c.rd_addr = 32'h0000_1230;
        c.exp_lat = 2;
        cmd_q[0].push_back(c);
        wait_done(20, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL read_only_timeout: got busy required done"); end
        tests++;
        if (bus.c0_line !== {32{4'hA}}) begin
            fails++;
            $display("FAIL read_only_c0_line: got %h required %h", bus.c0_line, {32{4'hA}});
        end
        tests++;
        if (bus.c1_line !== '0) begin
            fails++;
            $display("FAIL read_only_c1_line: got %h required 0", bus.c1_line);
        end
        tests++;
        if (mem_log.size() != 1 || mem_log[0].wr || mem_log[0].addr !== 32'h0000_1230) begin
            fails++;
            $display("FAIL read_only_access: got %0d accesses, first addr %h, required one read of 00001230",
                mem_log.size(), (mem_log.size() > 0) ? mem_log[0].addr : 32'hx);
        end
    endtask

    task automatic test_evict_read();
        cmd_t c;
        bit ok;
        logic [LW-1:0] ev_line;
        ev_line = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
        mem_delay = 1;
        mem_log.delete();
        c = '0;
        c.rd = 1'b1;
        c.ev = 1'b1;
        c.rd_addr = 32'h0000_7890;
        c.ev_addr = 32'h0000_4560;
        c.ev_line = ev_line;
        c.exp_lat = 5;
        cmd_q[1].push_back(c);
        wait_done(30, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL evict_read_timeout: got busy required done"); end
        tests++;
        if (mem_log.size() != 2) begin
            fails++;
            $display("FAIL evict_read_count: got %0d accesses required 2", mem_log.size());
        end else begin
            tests++;
            if (!mem_log[0].wr || mem_log[0].addr !== 32'h0000_4560 || mem_log[0].data !== ev_line) begin
                fails++;
                $display("FAIL evict_first_write: got wr=%b addr=%h data=%h required wr=1 addr=00004560 data=%h",
                    mem_log[0].wr, mem_log[0].addr, mem_log[0].data, ev_line);
            end
            tests++;
            if (mem_log[1].wr || mem_log[1].addr !== 32'h0000_7890) begin
                fails++;
                $display("FAIL evict_then_read: got wr=%b addr=%h required wr=0 addr=00007890",
                    mem_log[1].wr, mem_log[1].addr);
            end
        end
        mem_delay = 0;
    endtask

    task automatic test_evict_only();
        cmd_t c;
        bit ok;
        mem_log.delete();
        c = '0;
        c.ev = 1'b1;
        c.ev_addr = 32'h0000_2000;
        c.ev_line = {4{32'hFEED_F00D}};
        c.exp_lat = 2;
        cmd_q[0].push_back(c);
        wait_done(20, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL evict_only_timeout: got busy required done"); end
        tests++;
        if (bus.c0_line !== {32{4'hA}}) begin
            fails++;
            $display("FAIL evict_only_line_kept: got %h required %h", bus.c0_line, {32{4'hA}});
        end
        tests++;
        if (mem_log.size() != 1 || !mem_log[0].wr || mem_log[0].addr !== 32'h0000_2000) begin
            fails++;
            $display("FAIL evict_only_access: got %0d accesses required one write to 00002000", mem_log.size());
        end
    endtask

    task automatic test_drop_during_read();
        cmd_t c;
        bit ok;
        mem_delay = 2;
        mem_log.delete();
        c = '0;
        c.rd = 1'b1;
        c.rd_addr = 32'h0000_6000;
        c.drop_in_read = 1'b1;
        c.exp_lat = 4;
        cmd_q[0].push_back(c);
        wait_done(30, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL drop_timeout: got busy required done"); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if ({bus.mem_wren, bus.mem_rden, bus.c0_ack} !== 3'b000) begin
                fails++;
                $display("FAIL drop_no_regrant: got wren/rden/ack=%b required 000",
                    {bus.mem_wren, bus.mem_rden, bus.c0_ack});
            end
        end
        tests++;
        if (mem_log.size() != 1 || mem_log[0].addr !== 32'h0000_6000) begin
            fails++;
            $display("FAIL drop_access: got %0d accesses required one read of 00006000", mem_log.size());
        end
        mem_delay = 0;
    endtask

    task automatic test_back_to_back();
        cmd_t c;
        bit ok;
        reset = 1'b1;
        mem_delay = 0;
        ack_log.delete();
        for (int i = 0; i < 3; i++) begin
            c = '0;
            c.rd = 1'b1;
            c.rd_addr = 32'h0000_0100 + 32'(16 * i);
            c.exp_lat = -1;
            cmd_q[0].push_back(c);
            c.ev = 1'b1;
            c.ev_addr = 32'h0000_0300 + 32'(16 * i);
            c.ev_line = {4{32'hC0DE_0000 + 32'(i)}};
            c.rd_addr = 32'h0000_0400 + 32'(16 * i);
            cmd_q[1].push_back(c);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_done(100, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL b2b_timeout: got busy required done"); end
        tests++;
        if (ack_log.size() != 6) begin
            fails++;
            $display("FAIL b2b_ack_count: got %0d required 6", ack_log.size());
        end
        for (int i = 0; i < ack_log.size(); i++) begin
            tests++;
            if (ack_log[i] != i % 2) begin
                fails++;
                $display("FAIL b2b_grant_order[%0d]: got core%0d required core%0d", i, ack_log[i], i % 2);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        cmd_t c;
        bit ok;
        mem_delay = 10;
        c = '0;
        c.ev = 1'b1;
        c.ev_addr = 32'h0000_8000;
        c.ev_line = {4{32'h5555_AAAA}};
        c.exp_lat = -1;
        cmd_q[1].push_back(c);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_wren) break;
        end
        tests++;
        if (bus.mem_wren !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_write_reach: got wren=%b required 1", bus.mem_wren);
        end
        reset = 1'b1;
        abort_req = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus.mem_wren, bus.mem_rden, bus.c0_ack, bus.c1_ack} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_abort: got wren/rden/ack0/ack1=%b required 0000",
                {bus.mem_wren, bus.mem_rden, bus.c0_ack, bus.c1_ack});
        end
        tests++;
        if (bus.c0_line !== '0 || bus.c1_line !== '0) begin
            fails++;
            $display("FAIL reset_clears_lines: got c0=%h c1=%h required 0", bus.c0_line, bus.c1_line);
        end
        reset = 1'b0;
        mem_delay = 0;
        stray_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if ({bus.mem_wren, bus.mem_rden, bus.c0_ack, bus.c1_ack} !== 4'b0000) begin
                fails++;
                $display("FAIL stray_ack_ignored: got wren/rden/ack0/ack1=%b required 0000",
                    {bus.mem_wren, bus.mem_rden, bus.c0_ack, bus.c1_ack});
            end
        end
        c = '0;
        c.rd = 1'b1;
        c.rd_addr = 32'h0000_5000;
        c.exp_lat = 2;
        cmd_q[1].push_back(c);
        wait_done(20, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL recover_timeout: got busy required done"); end
        tests++;
        if (bus.c1_line !== mem_peek(32'h0000_5000)) begin
            fails++;
            $display("FAIL recover_line: got %h required %h", bus.c1_line, mem_peek(32'h0000_5000));
        end
    endtask

    initial begin
        test_reset();
        test_read_only();
        test_evict_read();
        test_evict_only();
        test_drop_during_read();
        test_back_to_back();
        test_reset_mid_write();
        for (int n = 0; n < 2; n++) begin
            tests++;
            if (exp_q[n].size() != 0) begin
                fails++;
                $display("FAIL leftover_expect core%0d: got %0d pending required 0", n, exp_q[n].size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 required earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule
